dmem_responder: RTL

- Responder (slave) end of the CPU data-memory interface. Accepts one load or store request at a time over a valid/ready request channel and returns a response over a valid/ready response channel.
- Backing store is an internal 64-bit-word register array. Access latency is programmable so the pipeline's stall and handshake logic can be exercised against a non-zero-latency memory.
- Replaces the combinational RAM behind the MEM stage.

---
 rtl/dmem_responder_if.sv | 25 ++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - request/response handshake bundle for the data-memory responder
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_wdt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  // Requester side (CPU MEM stage)
  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wdt, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Responder side (memory)
  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wdt, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder; DMEM_MISALIGN_CHECK_EN faults misaligned accesses
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned LATENCY   = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] CNT_INIT = 32'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, stateNext;
  logic [31:0] cnt, cntNext;
  logic        latch, doAccess, rspClear;

  logic        wenQ;
  logic [63:0] addrQ;
  logic [63:0] wdataQ;
  logic [1:0]  wdtQ;
  logic [63:0] rspRdata;
  logic        rspErr;

  logic [63:0] mem [DEPTH];

  // With LATENCY==1 the access happens on the acceptance edge, so it must
  // see the live request rather than the (not yet loaded) latched copy.
  logic        accWen;
  logic [63:0] accAddr;
  logic [63:0] accWdata;
  logic [1:0]  accWdt;
  assign accWen   = (state == IDLE) ? bus.req_wen   : wenQ;
  assign accAddr  = (state == IDLE) ? bus.req_addr  : addrQ;
  assign accWdata = (state == IDLE) ? bus.req_wdata : wdataQ;
  assign accWdt   = (state == IDLE) ? bus.req_wdt   : wdtQ;

  logic [63:0]      relAddr;
  logic [60:0]      wordIdx;
  logic             inRange;
  logic [IDX_W-1:0] memIdx;
  logic [2:0]       accOff, effOff, alignMask;
  logic [63:0]      laneMask;
  logic             accErr;
  logic [5:0]       shiftAmt;
  logic [63:0]      memWord, rdData, wrMask, wrData, newWord;
  logic             memWe;

  // Underflowing subtraction wraps to a huge index, but the explicit
  // addr >= BASE_ADDR test is what rejects addresses below the window.
  assign relAddr = accAddr - BASE_ADDR;
  assign wordIdx = 61'(relAddr >> 3);
  assign inRange = (accAddr >= BASE_ADDR) && (wordIdx < 61'(DEPTH));
  assign memIdx  = wordIdx[IDX_W-1:0];
  assign accOff  = accAddr[2:0];

  // Byte-lane mask and alignment mask per access width
  always_comb begin
    laneMask  = '1;
    alignMask = 3'b111;
    case (accWdt)
      2'd0:    begin laneMask = 64'h0000_0000_0000_00FF; alignMask = 3'b000; end
      2'd1:    begin laneMask = 64'h0000_0000_0000_FFFF; alignMask = 3'b001; end
      2'd2:    begin laneMask = 64'h0000_0000_FFFF_FFFF; alignMask = 3'b011; end
      default: begin laneMask = '1;                      alignMask = 3'b111; end
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = |(accOff & alignMask);
  assign effOff     = accOff;
  assign accErr     = !inRange || misaligned;
`else
  assign effOff     = accOff & ~alignMask;
  assign accErr     = !inRange;
`endif

  // Offsets are naturally aligned here, so lanes never cross the word.
  assign shiftAmt = {effOff, 3'b000};
  assign memWord  = mem[memIdx];
  assign rdData   = (memWord >> shiftAmt) & laneMask;
  assign wrMask   = laneMask << shiftAmt;
  assign wrData   = (accWdata & laneMask) << shiftAmt;
  assign newWord  = (memWord & ~wrMask) | (wrData & wrMask);
  assign memWe    = doAccess && accWen && !accErr && rst;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rspRdata;
  assign bus.rsp_err   = rspErr;

  // Next-state and control strobes
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    latch     = 1'b0;
    doAccess  = 1'b0;
    rspClear  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          latch   = 1'b1;
          cntNext = CNT_INIT;
          if (LATENCY > 1) begin
            stateNext = BUSY;
          end else begin
            doAccess  = 1'b1;
            stateNext = RESP;
          end
        end
      end
      BUSY: begin
        cntNext = cnt - 32'd1;
        if (cnt == 32'd1) begin
          doAccess  = 1'b1;
          stateNext = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rspClear  = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State and latency counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Request capture and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wenQ     <= 1'b0;
      addrQ    <= '0;
      wdataQ   <= '0;
      wdtQ     <= '0;
      rspRdata <= '0;
      rspErr   <= 1'b0;
    end else begin
      if (latch) begin
        wenQ   <= bus.req_wen;
        addrQ  <= bus.req_addr;
        wdataQ <= bus.req_wdata;
        wdtQ   <= bus.req_wdt;
      end
      if (doAccess) begin
        rspRdata <= (accErr || accWen) ? 64'd0 : rdData;
        rspErr   <= accErr;
      end else if (rspClear) begin
        rspRdata <= '0;
        rspErr   <= 1'b0;
      end
    end
  end

  // Backing store; deliberately not reset
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memIdx] <= newWord;
    end
  end
endmodule
